// File: rtl/logical_rshifter_pkg.sv
// rtl/logical_rshifter_pkg.sv - shared clog2 helper for the logical right shifter
package logical_rshifter_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/logical_rshifter_rshift_stage.sv
// rtl/logical_rshifter_rshift_stage.sv - one barrel stage: optional fixed right shift with sticky collection
module rshift_stage #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  input  logic             sticky_in,
  output logic [WIDTH-1:0] data_out,
  output logic             sticky_out
);

  logic [WIDTH-1:0] shifted;
  logic             dropped;

  assign shifted = {{SHIFT{1'b0}}, data_in[WIDTH-1:SHIFT]};
  assign dropped = |data_in[SHIFT-1:0];

  // Both mux arms are always defined, so a disabled stage forwards data cleanly.
  assign data_out   = en ? shifted : data_in;
  assign sticky_out = sticky_in | (en & dropped);

endmodule

// File: rtl/logical_rshifter.sv
// rtl/logical_rshifter.sv - registered log2 barrel logical right shifter with sticky output
module logical_rshifter
  import logical_rshifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SW    = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [SW-1:0]    sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] outwire,
  output logic             sticky,
  output logic             out_valid
);

  logic [WIDTH-1:0] stage_data   [SW+1];
  logic             stage_sticky [SW+1];

  assign stage_data[0]   = in;
  assign stage_sticky[0] = 1'b0;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    rshift_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k)
    ) u_stage (
      .data_in    (stage_data[k]),
      .en         (sel[k]),
      .sticky_in  (stage_sticky[k]),
      .data_out   (stage_data[k+1]),
      .sticky_out (stage_sticky[k+1])
    );
  end

  // Result registers hold across idle cycles; only out_valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outwire   <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        outwire <= stage_data[SW];
        sticky  <= stage_sticky[SW];
      end
    end
  end

endmodule

// File: tb/tb_logical_rshifter.sv
// tb/tb_logical_rshifter.sv - scoreboard bench for logical_rshifter at WIDTH=32
module tb_logical_rshifter;

  logic        clk;
  logic        rst;
  logic [31:0] in;
  logic [4:0]  sel;
  logic        in_valid;
  logic [31:0] outwire;
  logic        sticky;
  logic        out_valid;

  typedef struct {
    logic [31:0] d;
    logic        st;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp;
  int          n_bad;
  logic [31:0] held_d;
  logic        held_st;

  logical_rshifter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .sel       (sel),
    .in_valid  (in_valid),
    .outwire   (outwire),
    .sticky    (sticky),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] d, input logic [4:0] s);
    exp_t        e;
    logic [31:0] mask;
    mask = (32'd1 << s) - 32'd1;
    e.d  = d >> s;
    e.st = |(d & mask);
    return e;
  endfunction

  // One clock: drive at negedge, check 1 time unit after the capturing edge.
  task automatic cycle(input string tag, input logic v, input logic [31:0] d, input logic [4:0] s);
    exp_t e;
    @(negedge clk);
    in       = d;
    sel      = s;
    in_valid = v;
    if (v) sbq.push_back(model(d, s));
    @(posedge clk);
    #1;
    if (v) begin
      n_cmp++;
      assert (sbq.size() > 0) else begin
        n_bad++;
        $error("FAIL %s_sb_empty observed=0 expected=1", tag);
      end
      if (sbq.size() > 0) begin
        e       = sbq.pop_front();
        held_d  = e.d;
        held_st = e.st;
      end
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    end else begin
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    end
    chk({tag, "_out"}, outwire, held_d);
    chk({tag, "_sticky"}, {31'b0, sticky}, {31'b0, held_st});
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    held_d   = '0;
    held_st  = 1'b0;
    rst      = 1'b1;
    in       = 32'hFFFF_FFFF;
    sel      = 5'd3;
    in_valid = 1'b1;

    // Reset dominates even with a valid input presented across edges.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", outwire, 32'd0);
    chk("rst_sticky", {31'b0, sticky}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;

    cycle("first_after_rst", 1'b1, 32'h8000_0001, 5'd1);
    cycle("ff_sel4", 1'b1, 32'hFFFF_FFFF, 5'd4);
    cycle("ff_sel2", 1'b1, 32'hFFFF_FFFF, 5'd2);
    cycle("ff_sel1", 1'b1, 32'hFFFF_FFFF, 5'd1);
    cycle("msb_sel31", 1'b1, 32'h8000_0000, 5'd31);
    cycle("f_sel4", 1'b1, 32'h0000_000F, 5'd4);
    cycle("pass_sel0", 1'b1, 32'h1234_5678, 5'd0);
    cycle("hold1", 1'b0, 32'hDEAD_BEEF, 5'd7);
    cycle("hold2", 1'b0, 32'h0000_0000, 5'd0);
    cycle("odd_sel16", 1'b1, 32'hA5A5_0000, 5'd16);
    cycle("all_sel31", 1'b1, 32'hFFFF_FFFF, 5'd31);

    // Asynchronous reset between edges clears a loaded result at once.
    cycle("preload", 1'b1, 32'hCAFE_F00D, 5'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_out", outwire, 32'd0);
    chk("async_sticky", {31'b0, sticky}, 32'd0);
    chk("async_valid", {31'b0, out_valid}, 32'd0);
    rst     = 1'b0;
    held_d  = '0;
    held_st = 1'b0;

    // Reset during an input's setup window: that input is never captured.
    @(negedge clk);
    in       = 32'h7777_7777;
    sel      = 5'd2;
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("inflight_out", outwire, 32'd0);
    chk("inflight_valid", {31'b0, out_valid}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    cycle("post_inflight", 1'b0, 32'h0, 5'd0);
    cycle("recover", 1'b1, 32'h0000_0100, 5'd9);

    for (int i = 0; i < 48; i++) begin
      cycle("sweep", ($urandom_range(0, 4) != 0), $urandom, 5'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
